// File: rtl/cpu_bus_arbiter_if.sv
// Core fetch/data request-response buses plus the shared single-beat memory port.
// slave = arbiter side, master = core and memory side.
interface cpu_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              iresp_addr_ok;
    logic              iresp_data_ok;
    logic [31:0]       iresp_data;

    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [2:0]        dreq_size;
    logic [7:0]        dreq_strobe;
    logic [DATA_W-1:0] dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic [DATA_W-1:0] dresp_data;

    logic              mreq_valid;
    logic [ADDR_W-1:0] mreq_addr;
    logic [2:0]        mreq_size;
    logic [7:0]        mreq_strobe;
    logic [DATA_W-1:0] mreq_data;
    logic              mresp_addr_ok;
    logic              mresp_data_ok;
    logic [DATA_W-1:0] mresp_data;

    modport slave (
        input  ireq_valid, ireq_addr,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  mresp_addr_ok, mresp_data_ok, mresp_data,
        output iresp_addr_ok, iresp_data_ok, iresp_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        output mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data
    );

    modport master (
        output ireq_valid, ireq_addr,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output mresp_addr_ok, mresp_data_ok, mresp_data,
        input  iresp_addr_ok, iresp_data_ok, iresp_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        input  mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Round-robin arbiter serialising core fetch and data requests onto one single-beat memory port.
// Zero-cycle request forwarding, one transaction in flight; requesters hold until their *_data_ok.
module cpu_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    cpu_bus_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        I_ADDR,
        I_DATA,
        D_ADDR,
        D_DATA
    } state_t;

    localparam logic [2:0] FETCH_SIZE = 3'd2;

    state_t state;
    logic   last_d;

    logic idle;
    logic grant_i;
    logic grant_d;
    logic i_req;
    logic d_req;
    logic i_done;
    logic d_done;

    // Both pending: serve whichever requester did not win the previous grant.
    always_comb begin
        idle    = (state == IDLE);
        grant_d = idle && bus.dreq_valid && (!bus.ireq_valid || !last_d);
        grant_i = idle && bus.ireq_valid && !grant_d;
        i_req   = grant_i || (state == I_ADDR);
        d_req   = grant_d || (state == D_ADDR);
        // A completion only counts once the address has been (or is being) accepted.
        i_done  = bus.mresp_data_ok &&
                  ((state == I_DATA) || ((state == I_ADDR) && bus.mresp_addr_ok));
        d_done  = bus.mresp_data_ok &&
                  ((state == D_DATA) || ((state == D_ADDR) && bus.mresp_addr_ok));
    end

    always_comb begin
        bus.mreq_valid  = i_req || d_req;
        bus.mreq_addr   = {ADDR_W{1'b0}};
        bus.mreq_size   = 3'd0;
        bus.mreq_strobe = 8'd0;
        bus.mreq_data   = {DATA_W{1'b0}};
        if (d_req) begin
            bus.mreq_addr   = bus.dreq_addr;
            bus.mreq_size   = bus.dreq_size;
            bus.mreq_strobe = bus.dreq_strobe;
            bus.mreq_data   = bus.dreq_data;
        end else if (i_req) begin
            bus.mreq_addr   = bus.ireq_addr;
            bus.mreq_size   = FETCH_SIZE;
        end
    end

    always_comb begin
        bus.iresp_addr_ok = i_req && bus.mresp_addr_ok;
        bus.iresp_data_ok = i_done;
        bus.iresp_data    = 32'd0;
        if (i_done) begin
            bus.iresp_data = bus.ireq_addr[2] ? bus.mresp_data[32 +: 32]
                                              : bus.mresp_data[0 +: 32];
        end
        bus.dresp_addr_ok = d_req && bus.mresp_addr_ok;
        bus.dresp_data_ok = d_done;
        bus.dresp_data    = d_done ? bus.mresp_data : {DATA_W{1'b0}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        last_d <= 1'b1;
                        state  <= bus.mresp_addr_ok ? D_DATA : D_ADDR;
                    end else if (grant_i) begin
                        last_d <= 1'b0;
                        state  <= bus.mresp_addr_ok ? I_DATA : I_ADDR;
                    end
                end
                I_ADDR: begin
                    if (bus.mresp_addr_ok) begin
                        state <= bus.mresp_data_ok ? IDLE : I_DATA;
                    end
                end
                I_DATA: begin
                    if (bus.mresp_data_ok) begin
                        state <= IDLE;
                    end
                end
                D_ADDR: begin
                    if (bus.mresp_addr_ok) begin
                        state <= bus.mresp_data_ok ? IDLE : D_DATA;
                    end
                end
                D_DATA: begin
                    if (bus.mresp_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed vector table for the scripted corner cases, then randomized traffic
// against a transaction-level model of ownership, round-robin order and response routing.
module tb_cpu_bus_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cpu_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    cpu_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [63:0] ia;
        logic        dv;
        logic        aok;
        logic        dok;
        logic [63:0] md;
        logic        e_mv;
        logic [1:0]  e_own;
        logic        e_iaok;
        logic        e_idok;
        logic        e_daok;
        logic        e_ddok;
        logic [31:0] e_idat;
    } vec_t;

    vec_t tbl[$];

    localparam logic [63:0] IA1 = 64'h0000_0000_8000_0004;
    localparam logic [63:0] IA0 = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DA  = 64'h0000_0000_8000_1000;
    localparam logic [63:0] DD  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] MD1 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] MD2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] MD3 = 64'hAAAA_BBBB_CCCC_DDDD;

    task automatic add(input logic r, input logic iv, input logic [63:0] ia, input logic dv,
                       input logic aok, input logic dok, input logic [63:0] md,
                       input logic mv, input logic [1:0] own, input logic iaok, input logic idok,
                       input logic daok, input logic ddok, input logic [31:0] idat);
        vec_t v;
        v.rst = r; v.iv = iv; v.ia = ia; v.dv = dv; v.aok = aok; v.dok = dok; v.md = md;
        v.e_mv = mv; v.e_own = own; v.e_iaok = iaok; v.e_idok = idok;
        v.e_daok = daok; v.e_ddok = ddok; v.e_idat = idat;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [63:0] ia, input logic dv,
                         input logic [63:0] da, input logic [2:0] dsz, input logic [7:0] dst,
                         input logic [63:0] dd);
        rst             = r;
        bus.ireq_valid  = iv;
        bus.ireq_addr   = ia;
        bus.dreq_valid  = dv;
        bus.dreq_addr   = da;
        bus.dreq_size   = dsz;
        bus.dreq_strobe = dst;
        bus.dreq_data   = dd;
    endtask

    task automatic mem_drive(input logic aok, input logic dok, input logic [63:0] md);
        bus.mresp_addr_ok = aok;
        bus.mresp_data_ok = dok;
        bus.mresp_data    = md;
    endtask

    // Expected request fields follow from whichever requester should own the port.
    task automatic check_cycle(input string tag, input logic e_mv, input logic [1:0] e_own,
                               input logic e_iaok, input logic e_idok, input logic e_daok,
                               input logic e_ddok, input logic [31:0] e_idat,
                               input logic [63:0] e_ddat);
        chk({tag, " ctl(mv,iaok,idok,daok,ddok)"},
            {59'd0, bus.mreq_valid, bus.iresp_addr_ok, bus.iresp_data_ok,
             bus.dresp_addr_ok, bus.dresp_data_ok},
            {59'd0, e_mv, e_iaok, e_idok, e_daok, e_ddok});
        chk({tag, " iresp_data"}, {32'd0, bus.iresp_data}, {32'd0, e_idat});
        chk({tag, " dresp_data"}, bus.dresp_data, e_ddat);
        if (e_mv) begin
            if (e_own == 2'd2) begin
                chk({tag, " mreq_addr"}, bus.mreq_addr, bus.dreq_addr);
                chk({tag, " mreq_size"}, {61'd0, bus.mreq_size}, {61'd0, bus.dreq_size});
                chk({tag, " mreq_strobe"}, {56'd0, bus.mreq_strobe}, {56'd0, bus.dreq_strobe});
                chk({tag, " mreq_data"}, bus.mreq_data, bus.dreq_data);
            end else begin
                chk({tag, " mreq_addr"}, bus.mreq_addr, bus.ireq_addr);
                chk({tag, " mreq_size"}, {61'd0, bus.mreq_size}, 64'd2);
                chk({tag, " mreq_strobe"}, {56'd0, bus.mreq_strobe}, 64'd0);
                chk({tag, " mreq_data"}, bus.mreq_data, 64'd0);
            end
        end
    endtask

    // Random-phase model state
    int          own;        // 0 none, 1 fetch, 2 data
    bit          accepted;
    bit          last_was_d;
    bit          iv_r, dv_r;
    logic [63:0] ia_r, da_r, dd_r;
    logic [2:0]  dsz_r;
    logic [7:0]  dst_r;
    bit          mem_busy;
    int          mem_cnt;
    int          n_i_exp, n_d_exp, n_i_obs, n_d_obs;

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
        mem_drive(1'b0, 1'b0, 64'd0);
        repeat (2) @(posedge clk);

        add(1, 0, IA1, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 32'd0);
        add(0, 0, IA1, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 32'd0);
        // fetch, accepted in grant cycle, data two cycles later
        add(0, 1, IA1, 0, 1, 0, 64'd0, 1, 1, 1, 0, 0, 0, 32'd0);
        add(0, 1, IA1, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 32'd0);
        add(0, 1, IA1, 0, 0, 1, MD1,   0, 0, 0, 1, 0, 0, 32'h1122_3344);
        add(0, 0, IA1, 0, 0, 0, MD1,   0, 0, 0, 0, 0, 0, 32'd0);
        // store with three-cycle address stall
        add(0, 0, IA1, 1, 0, 0, 64'd0, 1, 2, 0, 0, 0, 0, 32'd0);
        add(0, 0, IA1, 1, 0, 0, 64'd0, 1, 2, 0, 0, 0, 0, 32'd0);
        add(0, 0, IA1, 1, 0, 0, 64'd0, 1, 2, 0, 0, 0, 0, 32'd0);
        add(0, 0, IA1, 1, 1, 0, 64'd0, 1, 2, 0, 0, 1, 0, 32'd0);
        add(0, 0, IA1, 1, 0, 1, MD2,   0, 0, 0, 0, 0, 1, 32'd0);
        add(0, 0, IA1, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 32'd0);
        // contention from reset: D, I, D, I
        add(1, 0, IA1, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 32'd0);
        add(0, 1, IA1, 1, 1, 0, 64'd0, 1, 2, 0, 0, 1, 0, 32'd0);
        add(0, 1, IA1, 1, 0, 1, MD2,   0, 0, 0, 0, 0, 1, 32'd0);
        add(0, 1, IA1, 1, 1, 0, 64'd0, 1, 1, 1, 0, 0, 0, 32'd0);
        add(0, 1, IA1, 1, 0, 1, MD1,   0, 0, 0, 1, 0, 0, 32'h1122_3344);
        add(0, 1, IA1, 1, 1, 0, 64'd0, 1, 2, 0, 0, 1, 0, 32'd0);
        add(0, 1, IA1, 1, 0, 1, MD2,   0, 0, 0, 0, 0, 1, 32'd0);
        add(0, 1, IA1, 1, 1, 0, 64'd0, 1, 1, 1, 0, 0, 0, 32'd0);
        add(0, 1, IA1, 1, 0, 1, MD1,   0, 0, 0, 1, 0, 0, 32'h1122_3344);
        // addr_ok and data_ok together in D_ADDR, pending fetch granted next cycle
        add(0, 1, IA1, 1, 0, 0, 64'd0, 1, 2, 0, 0, 0, 0, 32'd0);
        add(0, 1, IA1, 1, 1, 1, MD2,   1, 2, 0, 0, 1, 1, 32'd0);
        add(0, 1, IA1, 0, 0, 0, 64'd0, 1, 1, 0, 0, 0, 0, 32'd0);
        add(0, 1, IA1, 0, 1, 0, 64'd0, 1, 1, 1, 0, 0, 0, 32'd0);
        add(0, 1, IA1, 0, 0, 1, MD1,   0, 0, 0, 1, 0, 0, 32'h1122_3344);
        // reset in I_DATA, stale data_ok two cycles later
        add(0, 1, IA1, 0, 1, 0, 64'd0, 1, 1, 1, 0, 0, 0, 32'd0);
        add(1, 0, IA1, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 32'd0);
        add(0, 0, IA1, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 32'd0);
        add(0, 0, IA1, 0, 0, 1, MD1,   0, 0, 0, 0, 0, 0, 32'd0);
        // low-word fetch, with a stray data_ok in I_ADDR ignored
        add(0, 1, IA0, 0, 0, 0, 64'd0, 1, 1, 0, 0, 0, 0, 32'd0);
        add(0, 1, IA0, 0, 0, 1, MD3,   1, 1, 0, 0, 0, 0, 32'd0);
        add(0, 1, IA0, 0, 1, 0, 64'd0, 1, 1, 1, 0, 0, 0, 32'd0);
        add(0, 1, IA0, 0, 0, 1, MD3,   0, 0, 0, 1, 0, 0, 32'hCCCC_DDDD);
        add(0, 0, IA0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 32'd0);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i].rst, tbl[i].iv, tbl[i].ia, tbl[i].dv, DA, 3'd3, 8'hFF, DD);
            mem_drive(tbl[i].aok, tbl[i].dok, tbl[i].md);
            @(negedge clk);
            check_cycle($sformatf("vec%0d", i), tbl[i].e_mv, tbl[i].e_own, tbl[i].e_iaok,
                        tbl[i].e_idok, tbl[i].e_daok, tbl[i].e_ddok, tbl[i].e_idat,
                        tbl[i].e_ddok ? tbl[i].md : 64'd0);
        end

        // randomized traffic
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 3'd0, 8'd0, 64'd0);
        mem_drive(1'b0, 1'b0, 64'd0);
        own = 0; accepted = 0; last_was_d = 0;
        iv_r = 0; dv_r = 0; ia_r = 0; da_r = 0; dd_r = 0; dsz_r = 0; dst_r = 0;
        mem_busy = 0; mem_cnt = 0;
        n_i_exp = 0; n_d_exp = 0; n_i_obs = 0; n_d_obs = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        aok, dok;
            logic [63:0] md;
            logic        e_mv, e_iaok, e_idok, e_daok, e_ddok;
            logic [1:0]  e_own;
            logic [31:0] e_idat;
            logic [63:0] e_ddat;
            int          winner;

            @(posedge clk);
            #1;
            drive(1'b0, iv_r, ia_r, dv_r, da_r, dsz_r, dst_r, dd_r);
            #1;
            md  = {$urandom, $urandom};
            aok = bus.mreq_valid && !mem_busy && ($urandom_range(0, 2) != 0);
            dok = mem_busy && (mem_cnt == 0);
            mem_drive(aok, dok, md);
            @(negedge clk);

            e_mv = 0; e_own = 0; e_iaok = 0; e_idok = 0; e_daok = 0; e_ddok = 0;
            winner = 0;
            if (own == 0) begin
                if (dv_r && (!iv_r || !last_was_d)) winner = 2;
                else if (iv_r) winner = 1;
                if (winner != 0) begin
                    own        = winner;
                    accepted   = aok;
                    last_was_d = (winner == 2);
                    e_mv       = 1;
                    e_own      = 2'(winner);
                    e_iaok     = (winner == 1) && aok;
                    e_daok     = (winner == 2) && aok;
                end
            end else if (!accepted) begin
                e_mv   = 1;
                e_own  = 2'(own);
                e_iaok = (own == 1) && aok;
                e_daok = (own == 2) && aok;
                if (aok) accepted = 1;
            end else if (dok) begin
                e_idok = (own == 1);
                e_ddok = (own == 2);
                own = 0; accepted = 0;
            end
            e_idat = e_idok ? (ia_r[2] ? md[63:32] : md[31:0]) : 32'd0;
            e_ddat = e_ddok ? md : 64'd0;
            check_cycle($sformatf("rnd%0d", cyc), e_mv, e_own, e_iaok, e_idok, e_daok,
                        e_ddok, e_idat, e_ddat);
            if (bus.iresp_data_ok === 1'b1) n_i_obs++;
            if (bus.dresp_data_ok === 1'b1) n_d_obs++;

            if (e_idok) begin iv_r = 0; n_i_exp++; end
            if (e_ddok) begin dv_r = 0; n_d_exp++; end
            if (!iv_r && $urandom_range(0, 2) == 0) begin
                iv_r = 1;
                ia_r = {$urandom, $urandom} & ~64'h3;
            end
            if (!dv_r && $urandom_range(0, 2) == 0) begin
                dv_r  = 1;
                da_r  = {$urandom, $urandom};
                dsz_r = 3'($urandom_range(0, 3));
                dst_r = 8'($urandom);
                dd_r  = {$urandom, $urandom};
            end
            if (dok) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (aok) begin
                mem_busy = 1;
                mem_cnt  = $urandom_range(0, 3);
            end
        end
        chk("rnd fetch completions", 64'(n_i_obs), 64'(n_i_exp));
        chk("rnd data completions", 64'(n_d_obs), 64'(n_d_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
